// File: rtl/seg_share_ctrl.sv
// rtl/seg_share_ctrl.sv - round-robin sharing of one 4-digit 7-segment display among three requesters
// Optional feature: define SEG_SHARE_LOCK_EN to let a locked owner keep the display past the hold time.

module seg_share_ctrl #(
    parameter logic [23:0] HOLD_CYC = 24'd1_000_000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [2:0]  req,
    input  logic [15:0] d0,
    input  logic [15:0] d1,
    input  logic [15:0] d2,
    input  logic [2:0]  lock,
    output logic [2:0]  gnt,
    output logic [1:0]  owner,
    output logic [15:0] x,
    output logic        blank
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      state;
    logic [23:0] cnt;

    logic [1:0]  pick_all;
    logic [1:0]  pick_other;
    logic [2:0]  others;
    logic        owner_req;
    logic        lock_hold;
    logic        expired;
    logic [15:0] d_own;

    // Search begins one past the last grantee and wraps, so the last grantee is tried last.
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] r);
        logic [1:0] w;
        w = last;
        case (last)
            2'd0: begin
                if (r[1])      w = 2'd1;
                else if (r[2]) w = 2'd2;
                else if (r[0]) w = 2'd0;
            end
            2'd1: begin
                if (r[2])      w = 2'd2;
                else if (r[0]) w = 2'd0;
                else if (r[1]) w = 2'd1;
            end
            default: begin
                if (r[0])      w = 2'd0;
                else if (r[1]) w = 2'd1;
                else if (r[2]) w = 2'd2;
            end
        endcase
        return w;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] idx);
        logic [2:0] v;
        case (idx)
            2'd0:    v = 3'b001;
            2'd1:    v = 3'b010;
            default: v = 3'b100;
        endcase
        return v;
    endfunction

    function automatic logic [15:0] dsel(input logic [1:0] idx,
                                          input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic [15:0] c);
        logic [15:0] v;
        case (idx)
            2'd0:    v = a;
            2'd1:    v = b;
            default: v = c;
        endcase
        return v;
    endfunction

    // gnt is one-hot on owner while in GRANT, so masking with it isolates the owner's bits.
    always_comb begin
        pick_all   = rr_pick(owner, req);
        others     = req & ~gnt;
        pick_other = rr_pick(owner, others);
        owner_req  = |(req & gnt);
        expired    = (cnt == (HOLD_CYC - 24'd1));
        d_own      = dsel(owner, d0, d1, d2);
    end

`ifdef SEG_SHARE_LOCK_EN
    assign lock_hold = |(lock & gnt);
`else
    logic unused_lock;
    assign unused_lock = ^lock;
    assign lock_hold   = 1'b0;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            cnt   <= 24'd0;
            gnt   <= 3'b000;
            owner <= 2'd2;
            x     <= 16'h0000;
            blank <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state <= GRANT;
                        cnt   <= 24'd0;
                        gnt   <= onehot(pick_all);
                        owner <= pick_all;
                        x     <= dsel(pick_all, d0, d1, d2);
                        blank <= 1'b0;
                    end
                end
                GRANT: begin
                    if (!expired) begin
                        cnt <= cnt + 24'd1;
                        if (owner_req)
                            x <= d_own;
                    end else if ((|others) && !lock_hold) begin
                        cnt   <= 24'd0;
                        gnt   <= onehot(pick_other);
                        owner <= pick_other;
                        x     <= dsel(pick_other, d0, d1, d2);
                    end else if (owner_req || lock_hold) begin
                        // Counter stays saturated so a newcomer is served on the next edge.
                        if (owner_req)
                            x <= d_own;
                    end else begin
                        state <= IDLE;
                        cnt   <= 24'd0;
                        gnt   <= 3'b000;
                        x     <= 16'h0000;
                        blank <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
